dbus_bridge: RTL and testbench

//  Data-bus slave directly downstream of the core's load/store port (d_addr/d_*_req/d_*_ready).

---
 rtl/dbus_pkg.sv | 41 ++++
 rtl/dbus_bridge_if.sv | 25 ++
 rtl/dbus_apb_master.sv | 95 +++++++++
 rtl/dbus_bridge.sv | 184 ++++++++++++++++++
 tb/tb_dbus_bridge.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_pkg.sv
// dbus_pkg
//   Shared types for the data-bus bridge: the bridge FSM state encoding,
//   the address-region classification and the region decoder.
//   No ports; imported by dbus_bridge and its testbench.
package dbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAM_RD,
    RAM_WR,
    RAM_RDATA,
    P_SETUP,
    P_ACCESS,
    DONE,
    ERR
  } dbus_state_t;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_PER,
    REG_NONE
  } dbus_region_t;

  // A region hits when the address with its in-region offset bits cleared
  // equals the region base. The RAM region is word-addressed, hence the
  // extra factor of four in its size.
  function automatic dbus_region_t region_of(input logic [31:0] addr,
                                             input logic [31:0] ram_base,
                                             input int          ram_aw,
                                             input logic [31:0] per_base,
                                             input int          per_aw);
    logic [31:0] ram_mask;
    logic [31:0] per_mask;
    ram_mask = ~((32'd4 << ram_aw) - 32'd1);
    per_mask = ~((32'd1 << per_aw) - 32'd1);
    if ((addr & ram_mask) == ram_base)      return REG_RAM;
    else if ((addr & per_mask) == per_base) return REG_PER;
    else                                    return REG_NONE;
  endfunction

endpackage

// File: rtl/dbus_bridge_if.sv
// dbus_bridge_if
//   Core load/store port bundle between the core (master) and the bridge
//   (slave).
//   d_addr, d_rd_req, d_wr_req, d_wr_be, d_wr_data : core -> bridge
//   d_rd_ready, d_wr_ready, d_rd_data             : bridge -> core
interface dbus_bridge_if;
  logic [31:0] d_addr;
  logic        d_rd_req;
  logic        d_wr_req;
  logic [3:0]  d_wr_be;
  logic [31:0] d_wr_data;
  logic        d_rd_ready;
  logic        d_wr_ready;
  logic [31:0] d_rd_data;

  modport master (
    output d_addr, d_rd_req, d_wr_req, d_wr_be, d_wr_data,
    input  d_rd_ready, d_wr_ready, d_rd_data
  );

  modport slave (
    input  d_addr, d_rd_req, d_wr_req, d_wr_be, d_wr_data,
    output d_rd_ready, d_wr_ready, d_rd_data
  );
endinterface

// File: rtl/dbus_apb_master.sv
// dbus_apb_master
//   APB-style transfer engine for the bridge: one setup cycle, then access
//   cycles until p_ready_i or until TIMEOUT access cycles have elapsed.
//   clk, rst         : clock, synchronous active-high reset
//   start_i          : begin a transfer (captures write_i/addr_i/wdata_i/strb_i)
//   p_*_o / p_*_i    : peripheral bus
//   done_o           : combinational, access completes this cycle (p_ready seen)
//   timeout_o        : combinational, last allowed access cycle without p_ready
//   rdata_o          : p_rdata captured on completion
module dbus_apb_master #(
  parameter int PER_AW  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              write_i,
  input  logic [PER_AW-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        strb_i,
  output logic              p_sel_o,
  output logic              p_enable_o,
  output logic              p_write_o,
  output logic [PER_AW-1:0] p_addr_o,
  output logic [31:0]       p_wdata_o,
  output logic [3:0]        p_strb_o,
  input  logic [31:0]       p_rdata_i,
  input  logic              p_ready_i,
  output logic              done_o,
  output logic              timeout_o,
  output logic [31:0]       rdata_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic              p_sel_q;
  logic              p_enable_q;
  logic              p_write_q;
  logic [PER_AW-1:0] p_addr_q;
  logic [31:0]       p_wdata_q;
  logic [3:0]        p_strb_q;
  logic [CW-1:0]     cnt_q;
  logic [31:0]       rdata_q;

  // The counter holds the index of the current access cycle, so the
  // TIMEOUT-th access cycle is the one where it reads TIMEOUT-1.
  assign done_o    = p_enable_q & p_ready_i;
  assign timeout_o = p_enable_q & ~p_ready_i & (cnt_q == CW'(TIMEOUT - 1));

  // Setup -> access -> idle sequencing. The bus fields are captured at
  // start and held for the whole transfer; both completion and timeout
  // drop p_sel on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_sel_q    <= 1'b0;
      p_enable_q <= 1'b0;
      p_write_q  <= 1'b0;
      p_addr_q   <= '0;
      p_wdata_q  <= '0;
      p_strb_q   <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
    end else if (start_i) begin
      p_sel_q    <= 1'b1;
      p_enable_q <= 1'b0;
      p_write_q  <= write_i;
      p_addr_q   <= addr_i;
      p_wdata_q  <= wdata_i;
      p_strb_q   <= strb_i;
      cnt_q      <= '0;
    end else if (p_sel_q && !p_enable_q) begin
      p_enable_q <= 1'b1;
    end else if (p_enable_q) begin
      if (p_ready_i) begin
        rdata_q    <= p_rdata_i;
        p_sel_q    <= 1'b0;
        p_enable_q <= 1'b0;
      end else if (timeout_o) begin
        p_sel_q    <= 1'b0;
        p_enable_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign p_sel_o    = p_sel_q;
  assign p_enable_o = p_enable_q;
  assign p_write_o  = p_write_q;
  assign p_addr_o   = p_addr_q;
  assign p_wdata_o  = p_wdata_q;
  assign p_strb_o   = p_strb_q;
  assign rdata_o    = rdata_q;

endmodule

// File: rtl/dbus_bridge.sv
// dbus_bridge
//   Data-bus slave behind the core load/store port. Decodes each request to
//   the on-chip sync RAM, the APB-style peripheral bus, or an error
//   completion, and returns one-cycle ready pulses to release the core.
//   clk, rst             : clock, synchronous active-high reset
//   core (slave)         : core request/response bundle
//   ram_*_o / ram_rdata_i: sync SRAM port (1-cycle read latency)
//   p_*_o / p_*_i        : peripheral bus
//   err_clr_i            : clears bus_err_o
//   bus_err_o            : sticky unmapped/timeout flag
//   err_addr_o           : address of the first error since last clear
module dbus_bridge
  import dbus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE = 32'h0000_0000,
  parameter int          RAM_AW   = 12,
  parameter logic [31:0] PER_BASE = 32'h1000_0000,
  parameter int          PER_AW   = 12,
  parameter int          TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  dbus_bridge_if.slave      core,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              p_sel_o,
  output logic              p_enable_o,
  output logic              p_write_o,
  output logic [PER_AW-1:0] p_addr_o,
  output logic [31:0]       p_wdata_o,
  output logic [3:0]        p_strb_o,
  input  logic [31:0]       p_rdata_i,
  input  logic              p_ready_i,
  input  logic              err_clr_i,
  output logic              bus_err_o,
  output logic [31:0]       err_addr_o
);

  dbus_state_t       state_q;
  logic              wr_q;
  logic [31:0]       addr_q;
  logic              ram_en_q;
  logic [3:0]        ram_we_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [31:0]       ram_wdata_q;
  logic              rd_ready_q;
  logic              wr_ready_q;
  logic              bus_err_q;
  logic [31:0]       err_addr_q;

  logic              req_valid;
  dbus_region_t      req_region;
  logic              apb_start;
  logic              apb_done;
  logic              apb_timeout;
  logic [31:0]       apb_rdata;

  assign req_valid  = core.d_rd_req | core.d_wr_req;
  assign req_region = region_of(core.d_addr, RAM_BASE, RAM_AW, PER_BASE, PER_AW);
  assign apb_start  = (state_q == IDLE) && req_valid && (req_region == REG_PER);

  dbus_apb_master #(
    .PER_AW  (PER_AW),
    .TIMEOUT (TIMEOUT)
  ) u_apb (
    .clk        (clk),
    .rst        (rst),
    .start_i    (apb_start),
    .write_i    (~core.d_rd_req),
    .addr_i     (core.d_addr[PER_AW-1:0]),
    .wdata_i    (core.d_wr_data),
    .strb_i     (core.d_wr_be),
    .p_sel_o    (p_sel_o),
    .p_enable_o (p_enable_o),
    .p_write_o  (p_write_o),
    .p_addr_o   (p_addr_o),
    .p_wdata_o  (p_wdata_o),
    .p_strb_o   (p_strb_o),
    .p_rdata_i  (p_rdata_i),
    .p_ready_i  (p_ready_i),
    .done_o     (apb_done),
    .timeout_o  (apb_timeout),
    .rdata_o    (apb_rdata)
  );

  // Main FSM. Strobes and readies are registered and set on the edge that
  // enters the state they belong to, so they default to 0 every cycle.
  // A RAM store completes in its only strobe cycle; a RAM load needs one
  // more cycle for the SRAM data. The error flag is set after the clear so
  // a simultaneous new error wins, and err_addr keeps the first error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_ready_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      ram_en_q   <= 1'b0;
      ram_we_q   <= '0;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      if (err_clr_i) bus_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q      <= core.d_addr;
            wr_q        <= ~core.d_rd_req;
            ram_addr_q  <= core.d_addr[RAM_AW+1:2];
            ram_wdata_q <= core.d_wr_data;
            unique case (req_region)
              REG_RAM: begin
                ram_en_q <= 1'b1;
                if (core.d_rd_req) begin
                  state_q <= RAM_RD;
                end else begin
                  state_q    <= RAM_WR;
                  ram_we_q   <= core.d_wr_be;
                  wr_ready_q <= 1'b1;
                end
              end
              REG_PER: state_q <= P_SETUP;
              default: begin
                state_q    <= ERR;
                rd_ready_q <= core.d_rd_req;
                wr_ready_q <= ~core.d_rd_req;
                bus_err_q  <= 1'b1;
                if (!bus_err_q) err_addr_q <= core.d_addr;
              end
            endcase
          end
        end
        RAM_RD: begin
          state_q    <= RAM_RDATA;
          rd_ready_q <= 1'b1;
        end
        P_SETUP: state_q <= P_ACCESS;
        P_ACCESS: begin
          if (apb_done) begin
            state_q    <= DONE;
            rd_ready_q <= ~wr_q;
            wr_ready_q <= wr_q;
          end else if (apb_timeout) begin
            state_q    <= ERR;
            rd_ready_q <= ~wr_q;
            wr_ready_q <= wr_q;
            bus_err_q  <= 1'b1;
            if (!bus_err_q) err_addr_q <= addr_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data is only driven in a load ready cycle: straight from the SRAM
  // in RAM_RDATA, from the captured peripheral data in DONE, 0 for errors.
  always_comb begin
    core.d_rd_data = '0;
    if (rd_ready_q) begin
      if (state_q == RAM_RDATA)  core.d_rd_data = ram_rdata_i;
      else if (state_q == DONE)  core.d_rd_data = apb_rdata;
    end
  end

  assign core.d_rd_ready = rd_ready_q;
  assign core.d_wr_ready = wr_ready_q;
  assign ram_en_o        = ram_en_q;
  assign ram_we_o        = ram_we_q;
  assign ram_addr_o      = ram_addr_q;
  assign ram_wdata_o     = ram_wdata_q;
  assign bus_err_o       = bus_err_q;
  assign err_addr_o      = err_addr_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// tb_dbus_bridge
//   Directed self-checking bench for dbus_bridge with a behavioural sync
//   SRAM and a scripted peripheral that answers after a chosen number of
//   access cycles (0 = never answers).
module tb_dbus_bridge;
  import dbus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        p_sel;
  logic        p_enable;
  logic        p_write;
  logic [11:0] p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  p_strb;
  logic [31:0] p_rdata;
  logic        p_ready;
  logic        err_clr;
  logic        bus_err;
  logic [31:0] err_addr;

  int assertCount = 0;
  int failCount   = 0;

  int          perWait;
  int          accCnt;
  logic [3:0]  seenRamWe;
  logic [31:0] seenRamAddr;
  logic [31:0] seenPAddr;
  logic        seenPWrite;
  logic [3:0]  seenPStrb;
  logic [31:0] seenPWdata;

  int          cycles;
  logic [31:0] rdata;
  logic        gotRd;
  logic        gotWr;
  logic        readyAfter;

  logic [31:0] mem [0:4095];

  dbus_bridge_if core_if ();

  dbus_bridge #(
    .RAM_BASE (32'h0000_0000),
    .RAM_AW   (12),
    .PER_BASE (32'h1000_0000),
    .PER_AW   (12),
    .TIMEOUT  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .core        (core_if),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .p_sel_o     (p_sel),
    .p_enable_o  (p_enable),
    .p_write_o   (p_write),
    .p_addr_o    (p_addr),
    .p_wdata_o   (p_wdata),
    .p_strb_o    (p_strb),
    .p_rdata_i   (p_rdata),
    .p_ready_i   (p_ready),
    .err_clr_i   (err_clr),
    .bus_err_o   (bus_err),
    .err_addr_o  (err_addr)
  );

  // Free-running clock, posedge active.
  always #5 clk = ~clk;

  // Sync SRAM: byte-lane writes, read data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      if (ram_we == 4'h0) ram_rdata <= mem[ram_addr];
    end
  end

  // Called once per negedge: records bus activity and plays the peripheral,
  // raising p_ready during access cycle number perWait.
  task automatic observeBuses();
    if (ram_en) begin
      seenRamWe   = ram_we;
      seenRamAddr = {20'd0, ram_addr};
    end
    if (p_sel) begin
      seenPAddr  = {20'd0, p_addr};
      seenPWrite = p_write;
      seenPStrb  = p_strb;
      seenPWdata = p_wdata;
    end
    if (p_enable) accCnt++;
    else          accCnt = 0;
    p_ready = (perWait != 0) && (accCnt == perWait);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one request at a negedge, holds it until a ready pulse (bounded),
  // returns the latency in cycles and whether a ready was seen one cycle later.
  task automatic applyStimulus(input logic isRd, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] data,
                               input int waitCycles);
    perWait     = waitCycles;
    accCnt      = 0;
    seenRamWe   = 4'hx;
    seenRamAddr = 32'hx;
    seenPAddr   = 32'hx;
    cycles      = -1;
    rdata       = 32'hx;
    gotRd       = 1'b0;
    gotWr       = 1'b0;
    core_if.d_addr    = addr;
    core_if.d_wr_be   = be;
    core_if.d_wr_data = data;
    core_if.d_rd_req  = isRd;
    core_if.d_wr_req  = !isRd;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      observeBuses();
      if (core_if.d_rd_ready || core_if.d_wr_ready) begin
        cycles = i;
        rdata  = core_if.d_rd_data;
        gotRd  = core_if.d_rd_ready;
        gotWr  = core_if.d_wr_ready;
        break;
      end
    end
    core_if.d_rd_req = 1'b0;
    core_if.d_wr_req = 1'b0;
    @(negedge clk);
    observeBuses();
    readyAfter = core_if.d_rd_ready | core_if.d_wr_ready;
  endtask

  initial begin
    rst               = 1'b1;
    err_clr           = 1'b0;
    p_ready           = 1'b0;
    p_rdata           = 32'h0000_0055;
    perWait           = 0;
    accCnt            = 0;
    core_if.d_addr    = '0;
    core_if.d_rd_req  = 1'b0;
    core_if.d_wr_req  = 1'b0;
    core_if.d_wr_be   = '0;
    core_if.d_wr_data = '0;
    repeat (3) @(negedge clk);

    checkOutput("rst_rd_ready", {31'd0, core_if.d_rd_ready}, 32'd0);
    checkOutput("rst_wr_ready", {31'd0, core_if.d_wr_ready}, 32'd0);
    checkOutput("rst_rd_data",  core_if.d_rd_data, 32'd0);
    checkOutput("rst_ram_en",   {31'd0, ram_en}, 32'd0);
    checkOutput("rst_p_sel",    {31'd0, p_sel}, 32'd0);
    checkOutput("rst_bus_err",  {31'd0, bus_err}, 32'd0);
    checkOutput("rst_err_addr", err_addr, 32'd0);
    rst = 1'b0;

    $display("[TB] word store then load at 0x10");
    applyStimulus(1'b0, 32'h0000_0010, 4'hF, 32'hA5A5_1234, 0);
    checkOutput("st_latency",  cycles, 32'd1);
    checkOutput("st_wr_ready", {31'd0, gotWr}, 32'd1);
    checkOutput("st_ram_we",   {28'd0, seenRamWe}, 32'hF);
    checkOutput("st_ram_addr", seenRamAddr, 32'd4);
    checkOutput("st_one_pulse", {31'd0, readyAfter}, 32'd0);
    applyStimulus(1'b1, 32'h0000_0010, 4'h0, 32'h0, 0);
    checkOutput("ld_latency",  cycles, 32'd2);
    checkOutput("ld_rd_ready", {31'd0, gotRd}, 32'd1);
    checkOutput("ld_data",     rdata, 32'hA5A5_1234);

    $display("[TB] byte store to lane 2 of word 4");
    applyStimulus(1'b0, 32'h0000_0012, 4'h4, 32'hFFEE_FFFF, 0);
    checkOutput("bst_ram_we",  {28'd0, seenRamWe}, 32'h4);
    checkOutput("bst_ram_addr", seenRamAddr, 32'd4);
    applyStimulus(1'b1, 32'h0000_0010, 4'h0, 32'h0, 0);
    checkOutput("bst_readback", rdata, 32'hA5EE_1234);

    $display("[TB] peripheral read, ready on third access cycle");
    applyStimulus(1'b1, 32'h1000_0008, 4'h0, 32'h0, 3);
    checkOutput("prd_latency", cycles, 32'd5);
    checkOutput("prd_rd_ready", {31'd0, gotRd}, 32'd1);
    checkOutput("prd_data",    rdata, 32'h0000_0055);
    checkOutput("prd_p_addr",  seenPAddr, 32'h8);
    checkOutput("prd_p_write", {31'd0, seenPWrite}, 32'd0);
    checkOutput("prd_one_pulse", {31'd0, readyAfter}, 32'd0);
    checkOutput("prd_no_err",  {31'd0, bus_err}, 32'd0);

    $display("[TB] peripheral write at top of region");
    applyStimulus(1'b0, 32'h1000_0FFC, 4'h3, 32'hCAFE_F00D, 1);
    checkOutput("pwr_latency", cycles, 32'd3);
    checkOutput("pwr_wr_ready", {31'd0, gotWr}, 32'd1);
    checkOutput("pwr_p_addr",  seenPAddr, 32'hFFC);
    checkOutput("pwr_p_write", {31'd0, seenPWrite}, 32'd1);
    checkOutput("pwr_p_strb",  {28'd0, seenPStrb}, 32'h3);
    checkOutput("pwr_p_wdata", seenPWdata, 32'hCAFE_F00D);

    $display("[TB] peripheral timeout");
    applyStimulus(1'b1, 32'h1000_0008, 4'h0, 32'h0, 0);
    checkOutput("to_latency",  cycles, 32'd18);
    checkOutput("to_rd_ready", {31'd0, gotRd}, 32'd1);
    checkOutput("to_data",     rdata, 32'd0);
    checkOutput("to_bus_err",  {31'd0, bus_err}, 32'd1);
    checkOutput("to_err_addr", err_addr, 32'h1000_0008);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("clr1_bus_err", {31'd0, bus_err}, 32'd0);

    $display("[TB] unmapped accesses");
    applyStimulus(1'b1, 32'h2000_0000, 4'h0, 32'h0, 0);
    checkOutput("um1_latency", cycles, 32'd1);
    checkOutput("um1_data",    rdata, 32'd0);
    checkOutput("um1_bus_err", {31'd0, bus_err}, 32'd1);
    checkOutput("um1_err_addr", err_addr, 32'h2000_0000);
    applyStimulus(1'b0, 32'h3000_0000, 4'hF, 32'h1111_2222, 0);
    checkOutput("um2_latency", cycles, 32'd1);
    checkOutput("um2_wr_ready", {31'd0, gotWr}, 32'd1);
    checkOutput("um2_err_addr", err_addr, 32'h2000_0000);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("clr2_bus_err", {31'd0, bus_err}, 32'd0);

    $display("[TB] reset during peripheral access");
    perWait = 0;
    accCnt  = 0;
    core_if.d_addr   = 32'h1000_0008;
    core_if.d_rd_req = 1'b1;
    repeat (3) begin
      @(negedge clk);
      observeBuses();
    end
    checkOutput("rsta_in_access", {31'd0, p_enable}, 32'd1);
    rst = 1'b1;
    core_if.d_rd_req = 1'b0;
    @(negedge clk);
    observeBuses();
    checkOutput("rsta_p_sel",    {31'd0, p_sel}, 32'd0);
    checkOutput("rsta_p_enable", {31'd0, p_enable}, 32'd0);
    checkOutput("rsta_rd_ready", {31'd0, core_if.d_rd_ready}, 32'd0);
    checkOutput("rsta_fsm_idle", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    observeBuses();
    checkOutput("rsta_no_late_ready", {31'd0, core_if.d_rd_ready}, 32'd0);
    applyStimulus(1'b1, 32'h0000_0010, 4'h0, 32'h0, 0);
    checkOutput("rsta_next_latency", cycles, 32'd2);
    checkOutput("rsta_next_data",    rdata, 32'hA5EE_1234);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
